reg_mul_unit: RTL and testbench

Iterative 64×64 shift-add multiplier sitting between the register file read ports and its write port.
- Takes operands from the register file outputs (readData1/readData2).
- Produces the 64-bit product over 64 cycles.
- Retires it through a one-cycle write-back request (writeReg/writeData/regWrite) that drives the register file write port.
- Used for MUL (and optionally UMULH) in the LEGv8 datapath, where a single-cycle multiplier is too large.

---
 rtl/reg_mul_unit.sv | 137 +++++++++++++
 tb/tb_reg_mul_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_mul_unit.sv
// reg_mul_unit: iterative shift-add unsigned multiplier feeding the regfile write port.
// Define MUL_UMULH_EN to allow the upper product half (UMULH) via the high input.
module reg_mul_unit #(
    parameter int WIDTH   = 64,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               high,
    input  logic [WIDTH-1:0]   opA,
    input  logic [WIDTH-1:0]   opB,
    input  logic [REGBITS-1:0] dest,
    output logic               busy,
    output logic               done,
    output logic [REGBITS-1:0] writeReg,
    output logic [WIDTH-1:0]   writeData,
    output logic               regWrite
);

    localparam int CNTW = $clog2(WIDTH);
    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);
    // Highest register index is the zero register; writes to it are dropped.
    localparam logic [REGBITS-1:0] XZR = {REGBITS{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WB
    } state_t;

    state_t               r_state;
    logic [CNTW-1:0]      r_count;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mcand;
    logic [REGBITS-1:0]   r_dreg;
    logic                 r_hsel;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_regWrite;
    logic [REGBITS-1:0]   r_writeReg;
    logic [WIDTH-1:0]     r_writeData;

    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]     w_result;
    logic                 w_hsel_in;
    logic                 w_last;

    // Conditional add of the multiplicand into the upper half, carry kept.
    always_comb begin
        w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
        if (r_acc[0]) begin
            w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        end
    end

    // Carry lands in the MSB; the consumed multiplier bit falls off the LSB.
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    assign w_last     = (r_count == LAST);

`ifdef MUL_UMULH_EN
    assign w_hsel_in = high;
    assign w_result  = r_hsel ? w_acc_next[2*WIDTH-1:WIDTH]
                              : w_acc_next[WIDTH-1:0];
`else
    logic w_unused_hsel;
    assign w_hsel_in     = 1'b0;
    assign w_result      = w_acc_next[WIDTH-1:0];
    assign w_unused_hsel = high | r_hsel;
`endif

    // Control FSM, datapath state and registered write-back outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_dreg      <= '0;
            r_hsel      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_regWrite  <= 1'b0;
            r_writeReg  <= '0;
            r_writeData <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done      <= 1'b0;
                    r_regWrite  <= 1'b0;
                    r_writeReg  <= '0;
                    r_writeData <= '0;
                    if (start) begin
                        r_mcand <= opA;
                        r_acc   <= {{WIDTH{1'b0}}, opB};
                        r_dreg  <= dest;
                        r_hsel  <= w_hsel_in;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_state     <= S_WB;
                        r_done      <= 1'b1;
                        r_regWrite  <= (r_dreg != XZR);
                        r_writeReg  <= r_dreg;
                        r_writeData <= w_result;
                    end
                end
                S_WB: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_regWrite  <= 1'b0;
                    r_writeReg  <= '0;
                    r_writeData <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign regWrite  = r_regWrite;
    assign writeReg  = r_writeReg;
    assign writeData = r_writeData;

endmodule

// File: tb/tb_reg_mul_unit.sv
// tb_reg_mul_unit: directed-vector bench for the iterative multiplier.
// Cycle T is the cycle holding start; samples are taken on the falling edge.
module tb_reg_mul_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        high;
    logic [63:0] opA;
    logic [63:0] opB;
    logic [4:0]  dest;
    logic        busy;
    logic        done;
    logic [4:0]  writeReg;
    logic [63:0] writeData;
    logic        regWrite;

    int n_cmp = 0;
    int n_err = 0;

    reg_mul_unit #(.WIDTH(64), .REGBITS(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .high      (high),
        .opA       (opA),
        .opB       (opB),
        .dest      (dest),
        .busy      (busy),
        .done      (done),
        .writeReg  (writeReg),
        .writeData (writeData),
        .regWrite  (regWrite)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one request in cycle T; returns at the sample point of T+1.
    task automatic launch(input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] d, input logic h);
        opA   = a;
        opB   = b;
        dest  = d;
        high  = h;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        opA   = 64'hDEAD_BEEF_0BAD_F00D;
        opB   = 64'h5555_AAAA_5555_AAAA;
        dest  = 5'd17;
        high  = 1'b0;
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        high  = 1'b0;
        opA   = '0;
        opB   = '0;
        dest  = '0;
        skip(3);
        n_cmp++;
        if ({busy, done, regWrite} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags busy/done/regWrite=%b required 000",
                     {busy, done, regWrite});
        end
        n_cmp++;
        if (writeReg !== 5'd0 || writeData !== 64'd0) begin
            n_err++;
            $display("FAIL reset_data writeReg=%0d writeData=%h required 0/0",
                     writeReg, writeData);
        end
        start = 1'b1;
        opA   = 64'd4;
        opB   = 64'd4;
        skip(1);
        start = 1'b0;
        reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_wins busy=%b required 0", busy);
        end
        skip(1);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_start_dropped busy=%b required 0", busy);
        end
    endtask

    task automatic test_basic();
        launch(64'd3, 64'd5, 5'd4, 1'b0);
        for (int k = 1; k <= 64; k++) begin
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0 || regWrite !== 1'b0) begin
                n_err++;
                $display("FAIL basic_run T+%0d busy/done/rw=%b%b%b required 100",
                         k, busy, done, regWrite);
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({busy, done, regWrite} !== 3'b111) begin
            n_err++;
            $display("FAIL basic_wb_flags busy/done/rw=%b required 111",
                     {busy, done, regWrite});
        end
        n_cmp++;
        if (writeReg !== 5'd4) begin
            n_err++;
            $display("FAIL basic_wreg got %0d required 4", writeReg);
        end
        n_cmp++;
        if (writeData !== 64'd15) begin
            n_err++;
            $display("FAIL basic_wdata got %0d required 15", writeData);
        end
        skip(1);
        n_cmp++;
        if ({busy, done, regWrite} !== 3'b000 || writeData !== 64'd0
            || writeReg !== 5'd0) begin
            n_err++;
            $display("FAIL basic_after flags=%b wreg=%0d wdata=%h required 0s",
                     {busy, done, regWrite}, writeReg, writeData);
        end
    endtask

    task automatic test_full_range();
        logic [63:0] exp_hi;
`ifdef MUL_UMULH_EN
        exp_hi = 64'hFFFF_FFFF_FFFF_FFFE;
`else
        exp_hi = 64'h1;
`endif
        launch(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 1'b0);
        skip(64);
        n_cmp++;
        if (writeData !== 64'h1 || writeReg !== 5'd7 || regWrite !== 1'b1) begin
            n_err++;
            $display("FAIL full_lo wdata=%h wreg=%0d rw=%b required 1/7/1",
                     writeData, writeReg, regWrite);
        end
        skip(1);
        launch(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 1'b1);
        skip(64);
        n_cmp++;
        if (writeData !== exp_hi || regWrite !== 1'b1) begin
            n_err++;
            $display("FAIL full_hi wdata=%h rw=%b required %h/1",
                     writeData, regWrite, exp_hi);
        end
        skip(1);
    endtask

    task automatic test_xzr();
        launch(64'd9, 64'd9, 5'd31, 1'b0);
        for (int k = 1; k <= 66; k++) begin
            n_cmp++;
            if (regWrite !== 1'b0) begin
                n_err++;
                $display("FAIL xzr_rw T+%0d regWrite=%b required 0", k, regWrite);
            end
            if (k == 64) begin
                n_cmp++;
                if (done !== 1'b0) begin
                    n_err++;
                    $display("FAIL xzr_early_done done=%b required 0", done);
                end
            end
            if (k == 65) begin
                n_cmp++;
                if (done !== 1'b1 || writeReg !== 5'd31 || writeData !== 64'd81) begin
                    n_err++;
                    $display("FAIL xzr_wb done=%b wreg=%0d wdata=%0d required 1/31/81",
                             done, writeReg, writeData);
                end
            end
            if (k < 66) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int writes;
        writes = 0;
        opA   = 64'd2;
        opB   = 64'd3;
        dest  = 5'd5;
        high  = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 135; k++) begin
            @(negedge clk);
            if (regWrite === 1'b1) begin
                writes++;
                n_cmp++;
                if (k == 65) begin
                    if (writeData !== 64'd6 || writeReg !== 5'd5) begin
                        n_err++;
                        $display("FAIL b2b_first wdata=%0d wreg=%0d required 6/5",
                                 writeData, writeReg);
                    end
                end else if (k == 131) begin
                    if (writeData !== 64'd49 || writeReg !== 5'd5) begin
                        n_err++;
                        $display("FAIL b2b_second wdata=%0d wreg=%0d required 49/5",
                                 writeData, writeReg);
                    end
                end else begin
                    n_err++;
                    $display("FAIL b2b_stray write at T+%0d data=%0d required none",
                             k, writeData);
                end
            end
            if (k == 66) begin
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_idle busy=%b required 0", busy);
                end
            end
            if (k == 67) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_reaccept busy=%b required 1", busy);
                end
            end
            if (k == 10) begin
                opA = 64'd7;
                opB = 64'd7;
            end
            if (k == 100) start = 1'b0;
        end
        n_cmp++;
        if (writes !== 2) begin
            n_err++;
            $display("FAIL b2b_count writes=%0d required 2", writes);
        end
    endtask

    task automatic test_reset_midop();
        int rw_seen;
        rw_seen = 0;
        launch(64'd10, 64'd10, 5'd3, 1'b0);
        for (int k = 1; k <= 100; k++) begin
            if (regWrite === 1'b1) rw_seen++;
            if (k == 29) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL midop_busy_before busy=%b required 1", busy);
                end
            end
            if (k >= 31) begin
                n_cmp++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL midop_abandon T+%0d busy=%b done=%b required 0/0",
                             k, busy, done);
                end
            end
            if (k == 30) reset = 1'b1;
            if (k == 31) reset = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (rw_seen !== 0) begin
            n_err++;
            $display("FAIL midop_no_write pulses=%0d required 0", rw_seen);
        end
        launch(64'd10, 64'd10, 5'd3, 1'b0);
        skip(64);
        n_cmp++;
        if (writeData !== 64'd100 || regWrite !== 1'b1 || writeReg !== 5'd3) begin
            n_err++;
            $display("FAIL midop_fresh wdata=%0d rw=%b wreg=%0d required 100/1/3",
                     writeData, regWrite, writeReg);
        end
        skip(1);
    endtask

    task automatic test_zero();
        launch(64'h1234, 64'd0, 5'd9, 1'b0);
        skip(64);
        n_cmp++;
        if (writeData !== 64'd0 || regWrite !== 1'b1 || done !== 1'b1) begin
            n_err++;
            $display("FAIL zero_op wdata=%h rw=%b done=%b required 0/1/1",
                     writeData, regWrite, done);
        end
        skip(1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        high  = 1'b0;
        opA   = '0;
        opB   = '0;
        dest  = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_full_range();
        test_xzr();
        test_back_to_back();
        test_reset_midop();
        test_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
